fir_mac_sequencer: RTL and testbench

- Time-multiplexed FIR filter controller for the digital filter datapath.
- Owns a TAPS-deep signed sample ring buffer and a coefficient register file.
- Sequences one shared multiply-accumulate unit over all taps per accepted input sample, then emits a scaled, saturated 8-bit result.
- Sits between the filter input pins (x_i) and the output register (y_o). Coefficients are loaded at runtime through a simple write port.

---
 rtl/fir_seq_pkg.sv | 19 +
 rtl/fir_shift_sat.sv | 23 ++
 rtl/fir_mac_sequencer.sv | 94 +++++++++
 tb/tb_fir_mac_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg: shared FIR sequencer types, default sizes and saturation helpers.
package fir_seq_pkg;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;
  localparam int TAPS_DEF   = 8;
  localparam int DATA_W_DEF = 8;
  localparam int COEF_W_DEF = 8;
  localparam int SHIFT_DEF  = 6;
  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction
  localparam int ACC_W_DEF    = acc_w(DATA_W_DEF, COEF_W_DEF, TAPS_DEF);
  localparam int COEF_RST_DEF = 1 << SHIFT_DEF;
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction
endpackage

// File: rtl/fir_shift_sat.sv
// fir_shift_sat: optional round-half-up (FIR_ROUND_EN), arithmetic shift and clip to DATA_W.
module fir_shift_sat import fir_seq_pkg::*; #(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] y_o
);
  localparam logic signed [ACC_W:0] HI = (ACC_W+1)'(sat_max(DATA_W));
  localparam logic signed [ACC_W:0] LO = (ACC_W+1)'(sat_min(DATA_W));
`ifdef FIR_ROUND_EN
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(1 << (SHIFT - 1));
`else
  localparam logic signed [ACC_W:0] RND = '0;
`endif
  logic signed [ACC_W:0] ext, sum, sh;
  // one guard bit keeps the rounding add from wrapping
  assign ext = {acc_i[ACC_W-1], acc_i};
  assign sum = ext + RND;
  assign sh  = sum >>> SHIFT;
  assign y_o = (sh > HI) ? HI[DATA_W-1:0] : (sh < LO) ? LO[DATA_W-1:0] : sh[DATA_W-1:0];
endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR, one shared MAC over TAPS cycles per sample.
// Rounding before the shift is enabled with FIR_ROUND_EN (see fir_shift_sat).
module fir_mac_sequencer import fir_seq_pkg::*; #(
  parameter int TAPS   = TAPS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int SHIFT  = SHIFT_DEF,
  localparam int AW    = $clog2(TAPS),
  localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic                     x_valid_i,
  output logic                     x_ready_o,
  input  logic                     coef_we_i,
  input  logic [AW-1:0]            coef_addr_i,
  input  logic signed [COEF_W-1:0] coef_data_i,
  output logic signed [DATA_W-1:0] y_o,
  output logic                     y_valid_o,
  output logic                     busy_o
);
  localparam logic signed [COEF_W-1:0] COEF_RST = COEF_W'(1 << SHIFT);
  state_e                     state_q, state_d;
  logic signed [DATA_W-1:0]   smp_q [TAPS];
  logic signed [DATA_W-1:0]   smp_d [TAPS];
  logic signed [COEF_W-1:0]   coef_q [TAPS];
  logic signed [COEF_W-1:0]   coef_d [TAPS];
  logic signed [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [AW-1:0]              k_q, k_d, wr_q, wr_d, idx;
  logic signed [DATA_W-1:0]   y_q, y_d, y_sat;
  logic signed [DATA_W+COEF_W-1:0] prod;
  // newest sample sits at wr_q, so tap k reads k entries back
  assign idx       = wr_q - k_q;
  assign prod      = coef_q[k_q] * smp_q[idx];
  assign acc_sum   = acc_q + ACC_W'(prod);
  assign x_ready_o = state_q == IDLE;
  assign busy_o    = state_q != IDLE;
  assign y_valid_o = state_q == OUT;
  assign y_o       = y_q;
  fir_shift_sat #(.ACC_W(ACC_W), .DATA_W(DATA_W), .SHIFT(SHIFT)) u_sat (
    .acc_i(acc_sum),
    .y_o  (y_sat)
  );
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      k_q     <= '0;
      wr_q    <= '0;
      y_q     <= '0;
      for (int i = 0; i < TAPS; i++) begin
        smp_q[i]  <= '0;
        coef_q[i] <= (i == 0) ? COEF_RST : '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      wr_q    <= wr_d;
      y_q     <= y_d;
      smp_q   <= smp_d;
      coef_q  <= coef_d;
    end
  end
  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    coef_d  = coef_q;
    acc_d   = acc_q;
    k_d     = k_q;
    wr_d    = wr_q;
    y_d     = y_q;
    if (state_q == IDLE) begin
      if (coef_we_i) coef_d[coef_addr_i] = coef_data_i;
      if (x_valid_i) begin
        smp_d[wr_q] = x_i;
        acc_d       = '0;
        k_d         = '0;
        state_d     = MAC;
      end
    end else if (state_q == MAC) begin
      acc_d = acc_sum;
      k_d   = k_q + 1'b1;
      if (k_q == AW'(TAPS - 1)) begin
        y_d     = y_sat;
        wr_d    = wr_q + 1'b1;
        state_d = OUT;
      end
    end else begin
      state_d = IDLE;
    end
  end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed vectors, expected outputs queued and checked by a monitor.
module tb_fir_mac_sequencer;
  localparam int TAPS = 8;
  typedef struct {logic [7:0] y; int c;} exp_t;
  logic       clk = 0, reset_i = 0, x_valid_i = 0, coef_we_i = 0;
  logic [7:0] x_i = 0, coef_data_i = 0;
  logic [2:0] coef_addr_i = 0;
  logic [7:0] y_o;
  logic       x_ready_o, y_valid_o, busy_o;
  int         cyc = 0, checks = 0, errors = 0, pulses = 0, pushes = 0;
  exp_t       q[$];
  fir_mac_sequencer dut (
    .clk_i(clk), .reset_i(reset_i), .x_i(x_i), .x_valid_i(x_valid_i), .x_ready_o(x_ready_o),
    .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i), .coef_data_i(coef_data_i),
    .y_o(y_o), .y_valid_o(y_valid_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (y_valid_o) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_y y_o=%h at cycle %0d, none expected", y_o, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        pulses++;
        if (y_o !== e.y || cyc != e.c) begin
          errors++;
          $display("FAIL y_out y_o=%h cycle=%0d, required %h at cycle %0d", y_o, cyc, e.y, e.c);
        end
      end
    end
  end
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    x_valid_i = 0; coef_we_i = 0; reset_i = 1;
    tick();
    reset_i = 0;
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    coef_we_i = 1; coef_addr_i = a; coef_data_i = d;
    tick();
    coef_we_i = 0;
  endtask
  task automatic send(input logic [7:0] x, input logic [7:0] y, input bit expect_out);
    int t = 0;
    while (!x_ready_o && t < 50) begin tick(); t++; end
    if (!x_ready_o) begin
      checks++; errors++;
      $display("FAIL ready_timeout x_ready_o=%b required 1", x_ready_o);
    end else begin
      x_i = x; x_valid_i = 1;
      if (expect_out) begin q.push_back('{y, cyc + TAPS + 1}); pushes++; end
      tick();
      x_valid_i = 0;
    end
  endtask
  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || busy_o) && t < 200) begin tick(); t++; end
    if (q.size() != 0 || busy_o) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d required 0", q.size());
      q.delete();
    end
    tick();
  endtask
  initial begin
    int p0;
    logic [7:0] v;
    tick();
    do_reset();
    chk("rst_y", int'(y_o), 0);
    chk("rst_valid", int'(y_valid_o), 0);
    chk("rst_ready", int'(x_ready_o), 1);
    chk("rst_busy", int'(busy_o), 0);
    send(8'h40, 8'h40, 1);
    chk("mac_busy", int'(busy_o), 1);
    chk("mac_ready", int'(x_ready_o), 0);
    send(8'hC0, 8'hC0, 1);
    drain();
    do_reset();
    for (int k = 0; k < 8; k++) wr(3'(k), 8'(k + 1));
    for (int k = 0; k < 8; k++) send(k == 0 ? 8'h40 : 8'h00, 8'(k + 1), 1);
    drain();
    do_reset();
    for (int k = 0; k < 8; k++) wr(3'(k), 8'h7F);
    for (int k = 0; k < 8; k++) send(8'h7F, 8'h7F, 1);
    drain();
    do_reset();
    for (int k = 0; k < 8; k++) wr(3'(k), 8'h7F);
    for (int k = 0; k < 8; k++) send(8'h80, 8'h80, 1);
    drain();
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 100; i++) begin
      v = 8'(8'h05 + i);
      x_i = v; x_valid_i = 1;
      if (x_ready_o != (i % 10 == 0)) begin
        checks++; errors++;
        $display("FAIL bp_ready cycle %0d x_ready_o=%b required %b", i, x_ready_o, i % 10 == 0);
      end
      if (i % 10 == 0) begin q.push_back('{v, cyc + TAPS + 1}); pushes++; end
      tick();
    end
    x_valid_i = 0;
    drain();
    chk("bp_pulses", pulses - p0, 10);
    do_reset();
    send(8'h40, 8'h40, 1);
    wr(3'd0, 8'h20);
    send(8'h40, 8'h40, 1);
    drain();
    wr(3'd0, 8'h20);
    send(8'h40, 8'h20, 1);
    drain();
    chk("pre_abort_y", int'(y_o), 32);
    do_reset();
    send(8'h50, 8'h00, 0);
    tick();
    tick();
    reset_i = 1;
    tick();
    reset_i = 0;
    chk("abort_y", int'(y_o), 0);
    chk("abort_busy", int'(busy_o), 0);
    for (int i = 0; i < 12; i++) tick();
    send(8'h10, 8'h10, 1);
    drain();
    do_reset();
    wr(3'd0, 8'h01);
`ifdef FIR_ROUND_EN
    send(8'h20, 8'h01, 1);
`else
    send(8'h20, 8'h00, 1);
`endif
    drain();
    chk("total_pulses", pulses, pushes);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
